// File: rtl/bm_mult_share_sched.sv
// Shares one OPW x OPW unsigned multiplier among three requesters through a
// two-stage pipeline (operand register, result register) with a running accumulator.
module bm_mult_share_sched #(
  parameter int OPW  = 9,
  parameter int RESW = 36
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        req_valid,
  input  logic [3*OPW-1:0]  req_a,
  input  logic [3*OPW-1:0]  req_b,
  output logic [2:0]        req_ready,
  output logic              res_valid,
  output logic [1:0]        res_id,
  output logic [RESW-1:0]   res_data,
  input  logic              res_ready,
  input  logic              acc_clr,
  output logic [RESW-1:0]   acc_out,
  output logic              busy
);

  logic [1:0]        ptr;
  logic              s1_valid;
  logic [1:0]        s1_id;
  logic [OPW-1:0]    s1_a;
  logic [OPW-1:0]    s1_b;

  logic              stall;
  logic              gnt_any;
  logic [1:0]        gnt_idx;
  logic              accept;
  logic [OPW-1:0]    sel_a;
  logic [OPW-1:0]    sel_b;
  logic [2*OPW-1:0]  prod_full;
  logic [RESW-1:0]   prod;
  logic              s2_load;

  assign stall = res_valid & ~res_ready;

  // Round-robin search starting at ptr; the first requester found in order wins.
  always_comb begin
    logic [1:0] order [3];
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    case (ptr)
      2'd1:    begin order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd0; end
      2'd2:    begin order[0] = 2'd2; order[1] = 2'd0; order[2] = 2'd1; end
      default: begin order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; end
    endcase
    for (int k = 0; k < 3; k++) begin
      if (!gnt_any && req_valid[order[k]]) begin
        gnt_any = 1'b1;
        gnt_idx = order[k];
      end
    end
  end

  always_comb begin
    req_ready = 3'b000;
    if (gnt_any && !stall && !reset) begin
      req_ready = 3'b001 << gnt_idx;
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    sel_a = req_a[OPW-1:0];
    sel_b = req_b[OPW-1:0];
    case (gnt_idx)
      2'd1: begin
        sel_a = req_a[2*OPW-1:OPW];
        sel_b = req_b[2*OPW-1:OPW];
      end
      2'd2: begin
        sel_a = req_a[3*OPW-1:2*OPW];
        sel_b = req_b[3*OPW-1:2*OPW];
      end
      default: ;
    endcase
  end

  assign prod_full = s1_a * s1_b;
  assign prod      = RESW'(prod_full);
  assign s2_load   = ~stall & s1_valid;

  // Arbitration pointer and operand stage; operands are captured only on accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr      <= 2'd0;
      s1_valid <= 1'b0;
      s1_id    <= 2'd0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_id <= gnt_idx;
        s1_a  <= sel_a;
        s1_b  <= sel_b;
        ptr   <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_id    <= 2'd0;
      res_data  <= '0;
    end else if (!stall) begin
      res_valid <= s1_valid;
      res_id    <= s1_id;
      res_data  <= prod;
    end
  end

  // A clear coinciding with a load restarts the sum at that product.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_out <= '0;
    end else if (s2_load) begin
      acc_out <= acc_clr ? prod : acc_out + prod;
    end else if (acc_clr) begin
      acc_out <= '0;
    end
  end

  assign busy = s1_valid | res_valid;

endmodule

// File: tb/tb_bm_mult_share_sched.sv
// Self-checking bench for bm_mult_share_sched: grant table, scoreboard of
// expected results, and hand sequences for stall, clear collision and reset.
module tb_bm_mult_share_sched;

  localparam int OPW  = 9;
  localparam int RESW = 36;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [2:0]        req_valid = '0;
  logic [3*OPW-1:0]  req_a = '0;
  logic [3*OPW-1:0]  req_b = '0;
  logic [2:0]        req_ready;
  logic              res_valid;
  logic [1:0]        res_id;
  logic [RESW-1:0]   res_data;
  logic              res_ready = 1'b1;
  logic              acc_clr = 1'b0;
  logic [RESW-1:0]   acc_out;
  logic              busy;

  bm_mult_share_sched #(.OPW(OPW), .RESW(RESW)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .res_ready(res_ready), .acc_clr(acc_clr), .acc_out(acc_out), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]      id;
    logic [RESW-1:0] data;
  } exp_t;

  typedef struct {
    logic [2:0]       valid;
    logic [3*OPW-1:0] a;
    logic [3*OPW-1:0] b;
    logic [2:0]       exp_ready;
  } vec_t;

  exp_t            sb[$];
  int              total = 0;
  int              bad = 0;
  int              ptr_model = 0;
  logic [RESW-1:0] acc_model = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] grant(input int p, input logic [2:0] v);
    for (int k = 0; k < 3; k++) begin
      if (v[(p + k) % 3]) return 3'b001 << ((p + k) % 3);
    end
    return 3'b000;
  endfunction

  task automatic applyStimulus(input logic [2:0] v, input logic [3*OPW-1:0] a,
                               input logic [3*OPW-1:0] b, input logic rr, input logic clr);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    res_ready = rr;
    acc_clr   = clr;
  endtask

  // Samples at the falling edge, updates the model, then advances past the next rising edge.
  task automatic checkOutput();
    logic       stall;
    logic [2:0] exp;
    int         idx;
    exp_t       e;
    @(negedge clock);
    stall = res_valid & ~res_ready;
    exp = stall ? 3'b000 : grant(ptr_model, req_valid);
    check("req_ready", 64'(req_ready), 64'(exp));
    if (exp != 3'b000) begin
      idx = (exp == 3'b001) ? 0 : (exp == 3'b010) ? 1 : 2;
      e.id   = 2'(idx);
      e.data = RESW'(req_a[OPW*idx +: OPW]) * RESW'(req_b[OPW*idx +: OPW]);
      sb.push_back(e);
      ptr_model = (idx + 1) % 3;
    end
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("spurious_result", 64'(res_id), 64'd3);
      end else begin
        e = sb.pop_front();
        acc_model = acc_model + e.data;
        check("res_id", 64'(res_id), 64'(e.id));
        check("res_data", 64'(res_data), 64'(e.data));
        check("acc_out", 64'(acc_out), 64'(acc_model));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    applyStimulus(3'b000, '0, '0, 1'b1, 1'b0);
    while (sb.size() > 0 && n < 40) begin
      checkOutput();
      n++;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb.delete();
    ptr_model = 0;
    acc_model = '0;
  endtask

  vec_t vecs[10];

  initial begin
    // ptr walks 0 -> 1 -> 2 -> 0 -> 1 -> 0 -> 2 -> 1 -> 1 -> 0 across the table
    vecs[0] = '{3'b001, {9'd0,   9'd0,   9'd511}, {9'd0,   9'd0,   9'd511}, 3'b001};
    vecs[1] = '{3'b111, {9'd2,   9'd3,   9'd4},   {9'd5,   9'd6,   9'd7},   3'b010};
    vecs[2] = '{3'b111, {9'd100, 9'd3,   9'd4},   {9'd200, 9'd6,   9'd7},   3'b100};
    vecs[3] = '{3'b111, {9'd1,   9'd1,   9'd0},   {9'd1,   9'd1,   9'd511}, 3'b001};
    vecs[4] = '{3'b101, {9'd511, 9'd9,   9'd9},   {9'd1,   9'd9,   9'd9},   3'b100};
    vecs[5] = '{3'b110, {9'd8,   9'd255, 9'd1},   {9'd8,   9'd256, 9'd1},   3'b010};
    vecs[6] = '{3'b011, {9'd1,   9'd2,   9'd17},  {9'd1,   9'd2,   9'd19},  3'b001};
    vecs[7] = '{3'b000, {9'd1,   9'd1,   9'd1},   {9'd1,   9'd1,   9'd1},   3'b000};
    vecs[8] = '{3'b100, {9'd300, 9'd0,   9'd0},   {9'd301, 9'd0,   9'd0},   3'b100};
    vecs[9] = '{3'b010, {9'd0,   9'd510, 9'd0},   {9'd0,   9'd509, 9'd0},   3'b010};

    // Reset state, with requests already pending
    req_valid = 3'b111;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_id", 64'(res_id), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_acc", 64'(acc_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single request with maximum operands
    applyStimulus(3'b001, {9'd0, 9'd0, 9'd511}, {9'd0, 9'd0, 9'd511}, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(3'b000, '0, '0, 1'b1, 1'b0);
    checkOutput();
    check("single_res_valid", 64'(res_valid), 64'd1);
    check("single_res_data", 64'(res_data), 64'd261121);
    drain();
    check("single_acc", 64'(acc_out), 64'd261121);

    // Grant table
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].a, vecs[i].b, 1'b1, 1'b0);
      #3;
      check($sformatf("table_ready_%0d", i), 64'(req_ready), 64'(vecs[i].exp_ready));
      checkOutput();
    end
    drain();

    // All three requesters continuously
    doReset();
    applyStimulus(3'b111, {9'd7, 9'd5, 9'd3}, {9'd8, 9'd6, 9'd4}, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) checkOutput();
    drain();
    check("rr_acc98", 64'(acc_out), 64'd98);

    // Clear collides with loading a product of 20
    applyStimulus(3'b001, {9'd0, 9'd0, 9'd4}, {9'd0, 9'd0, 9'd5}, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(3'b000, '0, '0, 1'b1, 1'b1);
    acc_model = '0;
    checkOutput();
    check("clr_collide_acc", 64'(acc_out), 64'd20);
    check("clr_collide_data", 64'(res_data), 64'd20);
    applyStimulus(3'b000, '0, '0, 1'b1, 1'b1);
    checkOutput();
    acc_model = '0;
    check("clr_alone_acc", 64'(acc_out), 64'd0);
    applyStimulus(3'b000, '0, '0, 1'b1, 1'b0);

    // Backpressure for four cycles while a result is valid
    doReset();
    applyStimulus(3'b111, {9'd12, 9'd11, 9'd10}, {9'd4, 9'd3, 9'd2}, 1'b1, 1'b0);
    checkOutput();
    checkOutput();
    applyStimulus(3'b111, {9'd12, 9'd11, 9'd10}, {9'd4, 9'd3, 9'd2}, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput();
      check("bp_res_valid", 64'(res_valid), 64'd1);
      check("bp_res_id", 64'(res_id), 64'd0);
      check("bp_res_data", 64'(res_data), 64'd20);
    end
    drain();
    check("bp_acc", 64'(acc_out), 64'd53);

    // Reset with both stages full
    doReset();
    applyStimulus(3'b111, {9'd3, 9'd2, 9'd1}, {9'd3, 9'd2, 9'd1}, 1'b1, 1'b0);
    checkOutput();
    checkOutput();
    check("mid_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_res_valid", 64'(res_valid), 64'd0);
    check("mid_acc", 64'(acc_out), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_ready", 64'(req_ready), 64'd0);
    sb.delete();
    ptr_model = 0;
    acc_model = '0;
    #1;
    reset = 1'b0;
    applyStimulus(3'b110, {9'd6, 9'd5, 9'd0}, {9'd6, 9'd7, 9'd0}, 1'b1, 1'b0);
    #1;
    check("mid_first_grant", 64'(req_ready), 64'd2);
    checkOutput();
    drain();
    check("mid_acc_after", 64'(acc_out), 64'd35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
